// File: rtl/wb_arb.sv
// Writeback arbiter: merges ls / md / ip results onto the single register-file
// write port, with a 1-entry buffer per source and starvation-based priority boost.
module wb_arb #(
    parameter int STARVE_LIMIT = 3,
    parameter int CW           = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ls_wb_dst,
    input  logic [63:0] ls_wb_result,
    input  logic [63:0] ls_wb_pc,
    input  logic        ls_wb_wb_en,
    input  logic        ls_wb_valid,
    output logic        ls_wb_ready,
    input  logic [4:0]  md_wb_dst,
    input  logic [63:0] md_wb_result,
    input  logic [63:0] md_wb_pc,
    input  logic        md_wb_wb_en,
    input  logic        md_wb_valid,
    output logic        md_wb_ready,
    input  logic [4:0]  ip_wb_dst,
    input  logic [63:0] ip_wb_result,
    input  logic [63:0] ip_wb_pc,
    input  logic        ip_wb_wb_en,
    input  logic        ip_wb_valid,
    output logic        ip_wb_ready,
    output logic        wb_rf_wen,
    output logic [4:0]  wb_rf_dst,
    output logic [63:0] wb_rf_data,
    output logic        wb_retire_valid,
    output logic [63:0] wb_retire_pc,
    output logic [1:0]  wb_retire_src,
    output logic [63:0] wb_instret
);
    localparam logic [CW-1:0] W_LIMIT = CW'(STARVE_LIMIT);
    localparam logic [CW-1:0] W_MAX   = {CW{1'b1}};

    logic [4:0]    w_in_dst    [3];
    logic [63:0]   w_in_result [3];
    logic [63:0]   w_in_pc     [3];
    logic [2:0]    w_in_wben;
    logic [2:0]    w_in_valid;

    logic [2:0]    r_buf_valid;
    logic [2:0]    r_buf_wben;
    logic [4:0]    r_buf_dst    [3];
    logic [63:0]   r_buf_result [3];
    logic [63:0]   r_buf_pc     [3];
    logic [CW-1:0] r_wait       [3];

    logic [2:0]    w_cand_valid;
    logic [2:0]    w_starved;
    logic [2:0]    w_cand_wben;
    logic [4:0]    w_cand_dst    [3];
    logic [63:0]   w_cand_result [3];
    logic [63:0]   w_cand_pc     [3];
    logic          w_any;
    logic [1:0]    w_win_idx;
    logic [2:0]    w_win_oh;
    logic          w_sel_wben;
    logic [4:0]    w_sel_dst;
    logic [63:0]   w_sel_result;
    logic [63:0]   w_sel_pc;

    function automatic logic [1:0] f_lowest(input logic [2:0] m);
        if (m[0]) begin
            return 2'd0;
        end else if (m[1]) begin
            return 2'd1;
        end else begin
            return 2'd2;
        end
    endfunction

    assign w_in_dst[0]    = ls_wb_dst;
    assign w_in_dst[1]    = md_wb_dst;
    assign w_in_dst[2]    = ip_wb_dst;
    assign w_in_result[0] = ls_wb_result;
    assign w_in_result[1] = md_wb_result;
    assign w_in_result[2] = ip_wb_result;
    assign w_in_pc[0]     = ls_wb_pc;
    assign w_in_pc[1]     = md_wb_pc;
    assign w_in_pc[2]     = ip_wb_pc;
    assign w_in_wben      = {ip_wb_wb_en, md_wb_wb_en, ls_wb_wb_en};
    assign w_in_valid     = {ip_wb_valid, md_wb_valid, ls_wb_valid};

    // Ready depends only on buffer occupancy, so there is no input-to-ready path.
    assign ls_wb_ready = ~r_buf_valid[0];
    assign md_wb_ready = ~r_buf_valid[1];
    assign ip_wb_ready = ~r_buf_valid[2];

    // Per-source candidate: a buffered entry always shadows its own source's live input.
    always_comb begin
        for (int s = 0; s < 3; s++) begin
            w_cand_valid[s]  = r_buf_valid[s] | w_in_valid[s];
            w_starved[s]     = r_buf_valid[s] && (r_wait[s] >= W_LIMIT);
            w_cand_wben[s]   = r_buf_valid[s] ? r_buf_wben[s]   : w_in_wben[s];
            w_cand_dst[s]    = r_buf_valid[s] ? r_buf_dst[s]    : w_in_dst[s];
            w_cand_result[s] = r_buf_valid[s] ? r_buf_result[s] : w_in_result[s];
            w_cand_pc[s]     = r_buf_valid[s] ? r_buf_pc[s]     : w_in_pc[s];
        end
    end

    // Starved entries outrank everything else; ties resolve to the lowest index.
    always_comb begin
        w_any     = |w_cand_valid;
        w_win_idx = (|w_starved) ? f_lowest(w_starved) : f_lowest(w_cand_valid);
        case (w_win_idx)
            2'd0:    w_win_oh = {2'b00, w_any};
            2'd1:    w_win_oh = {1'b0, w_any, 1'b0};
            2'd2:    w_win_oh = {w_any, 2'b00};
            default: w_win_oh = 3'b000;
        endcase
        case (w_win_idx)
            2'd1: begin
                w_sel_wben   = w_cand_wben[1];
                w_sel_dst    = w_cand_dst[1];
                w_sel_result = w_cand_result[1];
                w_sel_pc     = w_cand_pc[1];
            end
            2'd2: begin
                w_sel_wben   = w_cand_wben[2];
                w_sel_dst    = w_cand_dst[2];
                w_sel_result = w_cand_result[2];
                w_sel_pc     = w_cand_pc[2];
            end
            default: begin
                w_sel_wben   = w_cand_wben[0];
                w_sel_dst    = w_cand_dst[0];
                w_sel_result = w_cand_result[0];
                w_sel_pc     = w_cand_pc[0];
            end
        endcase
    end

    // Buffer update: winners drain, losing buffered entries age, losing live inputs are captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf_valid <= 3'b000;
            r_buf_wben  <= 3'b000;
            for (int s = 0; s < 3; s++) begin
                r_buf_dst[s]    <= 5'd0;
                r_buf_result[s] <= 64'd0;
                r_buf_pc[s]     <= 64'd0;
                r_wait[s]       <= '0;
            end
        end else begin
            for (int s = 0; s < 3; s++) begin
                if (w_win_oh[s]) begin
                    r_buf_valid[s] <= 1'b0;
                    r_wait[s]      <= '0;
                end else if (r_buf_valid[s]) begin
                    if (r_wait[s] != W_MAX) begin
                        r_wait[s] <= r_wait[s] + CW'(1);
                    end
                end else if (w_in_valid[s]) begin
                    r_buf_valid[s]  <= 1'b1;
                    r_buf_wben[s]   <= w_in_wben[s];
                    r_buf_dst[s]    <= w_in_dst[s];
                    r_buf_result[s] <= w_in_result[s];
                    r_buf_pc[s]     <= w_in_pc[s];
                    r_wait[s]       <= CW'(1);
                end
            end
        end
    end

    // Registered writeback / retire outputs; payload holds when nothing is granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_rf_wen       <= 1'b0;
            wb_rf_dst       <= 5'd0;
            wb_rf_data      <= 64'd0;
            wb_retire_valid <= 1'b0;
            wb_retire_pc    <= 64'd0;
            wb_retire_src   <= 2'd0;
            wb_instret      <= 64'd0;
        end else if (w_any) begin
            wb_rf_wen       <= w_sel_wben && (w_sel_dst != 5'd0);
            wb_rf_dst       <= w_sel_dst;
            wb_rf_data      <= w_sel_result;
            wb_retire_valid <= 1'b1;
            wb_retire_pc    <= w_sel_pc;
            wb_retire_src   <= w_win_idx;
            wb_instret      <= wb_instret + 64'd1;
        end else begin
            wb_rf_wen       <= 1'b0;
            wb_retire_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_wb_arb.sv
// Directed bench for wb_arb: table of single-source vectors plus hand-written
// sequences for contention, starvation and mid-operation reset.
module tb_wb_arb;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ls_wb_dst,    md_wb_dst,    ip_wb_dst;
    logic [63:0] ls_wb_result, md_wb_result, ip_wb_result;
    logic [63:0] ls_wb_pc,     md_wb_pc,     ip_wb_pc;
    logic        ls_wb_wb_en,  md_wb_wb_en,  ip_wb_wb_en;
    logic        ls_wb_valid,  md_wb_valid,  ip_wb_valid;
    logic        ls_wb_ready,  md_wb_ready,  ip_wb_ready;
    logic        wb_rf_wen;
    logic [4:0]  wb_rf_dst;
    logic [63:0] wb_rf_data;
    logic        wb_retire_valid;
    logic [63:0] wb_retire_pc;
    logic [1:0]  wb_retire_src;
    logic [63:0] wb_instret;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_instret;

    always #5 clk = ~clk;

    wb_arb #(.STARVE_LIMIT(3), .CW(4)) dut (
        .clk(clk), .rst(rst),
        .ls_wb_dst(ls_wb_dst), .ls_wb_result(ls_wb_result), .ls_wb_pc(ls_wb_pc),
        .ls_wb_wb_en(ls_wb_wb_en), .ls_wb_valid(ls_wb_valid), .ls_wb_ready(ls_wb_ready),
        .md_wb_dst(md_wb_dst), .md_wb_result(md_wb_result), .md_wb_pc(md_wb_pc),
        .md_wb_wb_en(md_wb_wb_en), .md_wb_valid(md_wb_valid), .md_wb_ready(md_wb_ready),
        .ip_wb_dst(ip_wb_dst), .ip_wb_result(ip_wb_result), .ip_wb_pc(ip_wb_pc),
        .ip_wb_wb_en(ip_wb_wb_en), .ip_wb_valid(ip_wb_valid), .ip_wb_ready(ip_wb_ready),
        .wb_rf_wen(wb_rf_wen), .wb_rf_dst(wb_rf_dst), .wb_rf_data(wb_rf_data),
        .wb_retire_valid(wb_retire_valid), .wb_retire_pc(wb_retire_pc),
        .wb_retire_src(wb_retire_src), .wb_instret(wb_instret)
    );

    typedef struct {
        int          s;      // driven source, 3 = idle
        logic [4:0]  dst;
        logic [63:0] res;
        logic [63:0] pc;
        logic        en;
        logic        erv;
        logic        ewen;
        logic [4:0]  edst;
        logic [63:0] edata;
        logic [63:0] epc;
        logic [1:0]  esrc;
    } vec_t;

    vec_t vt [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs;
        ls_wb_valid = 1'b0; md_wb_valid = 1'b0; ip_wb_valid = 1'b0;
        ls_wb_dst = 5'd0; md_wb_dst = 5'd0; ip_wb_dst = 5'd0;
        ls_wb_result = 64'd0; md_wb_result = 64'd0; ip_wb_result = 64'd0;
        ls_wb_pc = 64'd0; md_wb_pc = 64'd0; ip_wb_pc = 64'd0;
        ls_wb_wb_en = 1'b0; md_wb_wb_en = 1'b0; ip_wb_wb_en = 1'b0;
    endtask

    task automatic drive(input int s, input logic [4:0] d, input logic [63:0] r,
                         input logic [63:0] p, input logic en);
        case (s)
            0: begin ls_wb_valid = 1'b1; ls_wb_dst = d; ls_wb_result = r; ls_wb_pc = p; ls_wb_wb_en = en; end
            1: begin md_wb_valid = 1'b1; md_wb_dst = d; md_wb_result = r; md_wb_pc = p; md_wb_wb_en = en; end
            2: begin ip_wb_valid = 1'b1; ip_wb_dst = d; ip_wb_result = r; ip_wb_pc = p; ip_wb_wb_en = en; end
            default: ;
        endcase
    endtask

    task automatic chk_grant(input string tag, input logic [1:0] src, input logic wen,
                             input logic [4:0] dst, input logic [63:0] data);
        chk({tag, ".retire_valid"}, 64'(wb_retire_valid), 64'd1);
        chk({tag, ".retire_src"}, 64'(wb_retire_src), 64'(src));
        chk({tag, ".rf_wen"}, 64'(wb_rf_wen), 64'(wen));
        chk({tag, ".rf_dst"}, 64'(wb_rf_dst), 64'(dst));
        chk({tag, ".rf_data"}, wb_rf_data, data);
    endtask

    initial begin
        vt[0] = '{2, 5'd5,  64'h1234, 64'h8000_0000, 1'b1, 1'b1, 1'b1, 5'd5, 64'h1234, 64'h8000_0000, 2'd2};
        vt[1] = '{3, 5'd0,  64'h0,    64'h0,         1'b0, 1'b0, 1'b0, 5'd5, 64'h1234, 64'h8000_0000, 2'd0};
        vt[2] = '{2, 5'd0,  64'hAA,   64'h8000_0004, 1'b1, 1'b1, 1'b0, 5'd0, 64'hAA,   64'h8000_0004, 2'd2};
        vt[3] = '{1, 5'd7,  64'h77,   64'h100,       1'b0, 1'b1, 1'b0, 5'd7, 64'h77,   64'h100,       2'd1};
        vt[4] = '{0, 5'd31, 64'hDEAD_BEEF_CAFE_F00D, 64'h200, 1'b1, 1'b1, 1'b1, 5'd31, 64'hDEAD_BEEF_CAFE_F00D, 64'h200, 2'd0};
        vt[5] = '{1, 5'd9,  64'h5,    64'h300,       1'b1, 1'b1, 1'b1, 5'd9, 64'h5,    64'h300,       2'd1};

        // Reset state
        rst = 1'b1;
        clr_inputs();
        tick();
        tick();
        chk("rst.rf_wen", 64'(wb_rf_wen), 64'd0);
        chk("rst.rf_dst", 64'(wb_rf_dst), 64'd0);
        chk("rst.rf_data", wb_rf_data, 64'd0);
        chk("rst.retire_valid", 64'(wb_retire_valid), 64'd0);
        chk("rst.retire_pc", wb_retire_pc, 64'd0);
        chk("rst.retire_src", 64'(wb_retire_src), 64'd0);
        chk("rst.instret", wb_instret, 64'd0);
        chk("rst.readies", 64'({ls_wb_ready, md_wb_ready, ip_wb_ready}), 64'd7);
        rst = 1'b0;
        exp_instret = 64'd0;

        // Table of single-source (or idle) cycles
        for (int i = 0; i < 6; i++) begin
            clr_inputs();
            drive(vt[i].s, vt[i].dst, vt[i].res, vt[i].pc, vt[i].en);
            tick();
            clr_inputs();
            if (vt[i].erv) exp_instret = exp_instret + 64'd1;
            chk($sformatf("vec%0d.retire_valid", i), 64'(wb_retire_valid), 64'(vt[i].erv));
            chk($sformatf("vec%0d.rf_wen", i), 64'(wb_rf_wen), 64'(vt[i].ewen));
            chk($sformatf("vec%0d.rf_dst", i), 64'(wb_rf_dst), 64'(vt[i].edst));
            chk($sformatf("vec%0d.rf_data", i), wb_rf_data, vt[i].edata);
            chk($sformatf("vec%0d.retire_pc", i), wb_retire_pc, vt[i].epc);
            if (vt[i].erv) chk($sformatf("vec%0d.retire_src", i), 64'(wb_retire_src), 64'(vt[i].esrc));
            chk($sformatf("vec%0d.instret", i), wb_instret, exp_instret);
            chk($sformatf("vec%0d.readies", i), 64'({ls_wb_ready, md_wb_ready, ip_wb_ready}), 64'd7);
        end

        // All three at once: drained in priority order over three cycles
        drive(0, 5'd1, 64'h11, 64'h400, 1'b1);
        drive(1, 5'd2, 64'h22, 64'h404, 1'b1);
        drive(2, 5'd3, 64'h33, 64'h408, 1'b1);
        tick();
        clr_inputs();
        chk_grant("all3.c1", 2'd0, 1'b1, 5'd1, 64'h11);
        chk("all3.c1.readies", 64'({ls_wb_ready, md_wb_ready, ip_wb_ready}), 64'b100);
        tick();
        chk_grant("all3.c2", 2'd1, 1'b1, 5'd2, 64'h22);
        chk("all3.c2.readies", 64'({ls_wb_ready, md_wb_ready, ip_wb_ready}), 64'b110);
        tick();
        chk_grant("all3.c3", 2'd2, 1'b1, 5'd3, 64'h33);
        chk("all3.c3.readies", 64'({ls_wb_ready, md_wb_ready, ip_wb_ready}), 64'b111);
        exp_instret = exp_instret + 64'd3;
        chk("all3.instret", wb_instret, exp_instret);
        tick();
        chk("all3.idle.retire_valid", 64'(wb_retire_valid), 64'd0);

        // Starvation: ls streams while ip waits; ip wins once its wait reaches 3
        drive(0, 5'd10, 64'hA0, 64'h500, 1'b1);
        drive(2, 5'd20, 64'hB0, 64'h600, 1'b1);
        tick();
        clr_inputs();
        chk_grant("starve.t1", 2'd0, 1'b1, 5'd10, 64'hA0);
        chk("starve.t1.ip_ready", 64'(ip_wb_ready), 64'd0);
        drive(0, 5'd11, 64'hA1, 64'h504, 1'b1);
        tick();
        clr_inputs();
        chk_grant("starve.t2", 2'd0, 1'b1, 5'd11, 64'hA1);
        drive(0, 5'd12, 64'hA2, 64'h508, 1'b1);
        tick();
        clr_inputs();
        chk_grant("starve.t3", 2'd0, 1'b1, 5'd12, 64'hA2);
        drive(0, 5'd13, 64'hA3, 64'h50C, 1'b1);
        tick();
        clr_inputs();
        chk_grant("starve.t4", 2'd2, 1'b1, 5'd20, 64'hB0);
        chk("starve.t4.pc", wb_retire_pc, 64'h600);
        chk("starve.t4.readies", 64'({ls_wb_ready, md_wb_ready, ip_wb_ready}), 64'b011);
        tick();
        chk_grant("starve.t5", 2'd0, 1'b1, 5'd13, 64'hA3);
        chk("starve.t5.ls_ready", 64'(ls_wb_ready), 64'd1);
        drive(0, 5'd14, 64'hA4, 64'h510, 1'b1);
        tick();
        clr_inputs();
        chk_grant("starve.t6", 2'd0, 1'b1, 5'd14, 64'hA4);
        exp_instret = exp_instret + 64'd6;
        chk("starve.instret", wb_instret, exp_instret);

        // Reset while md and ip are buffered
        drive(0, 5'd1, 64'h11, 64'h700, 1'b1);
        drive(1, 5'd2, 64'h22, 64'h704, 1'b1);
        drive(2, 5'd3, 64'h33, 64'h708, 1'b1);
        tick();
        clr_inputs();
        chk("rstmid.pre.readies", 64'({ls_wb_ready, md_wb_ready, ip_wb_ready}), 64'b100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid.readies", 64'({ls_wb_ready, md_wb_ready, ip_wb_ready}), 64'd7);
        chk("rstmid.rf_wen", 64'(wb_rf_wen), 64'd0);
        chk("rstmid.instret", wb_instret, 64'd0);
        tick();
        chk("rstmid.after.rf_wen", 64'(wb_rf_wen), 64'd0);
        chk("rstmid.after.retire_valid", 64'(wb_retire_valid), 64'd0);
        drive(0, 5'd4, 64'h44, 64'h800, 1'b1);
        tick();
        clr_inputs();
        chk_grant("rstmid.ls", 2'd0, 1'b1, 5'd4, 64'h44);
        chk("rstmid.ls.instret", wb_instret, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_arb.md
Name: wb_arb

Overview:
- Writeback arbiter downstream of the integer pipeline (1-cycle ALU), the load/store pipeline and the mul/div unit.
- Accepts one result per source per cycle and holds losing results in a 1-entry buffer per source.
- Grants one result per cycle to the single register-file write port; the same registered result drives the issue-stage bypass, the scoreboard clear and the retire/instret trace.

Parameters:
- STARVE_LIMIT, 3: cycles a buffered result may lose arbitration before it is forced to top priority; range 1..15.
- CW, 4: wait-counter width; must satisfy 2^CW > STARVE_LIMIT.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- For each source s in {ls, md, ip} (priority index 0, 1, 2):
  - s_wb_dst  in  5  destination register
  - s_wb_result  in  64  result data
  - s_wb_pc  in  64  instruction PC
  - s_wb_wb_en  in  1  register write requested
  - s_wb_valid  in  1  result valid
  - s_wb_ready  out  1  source may present a result
- wb_rf_wen  out  1  register-file write enable
- wb_rf_dst  out  5  write address
- wb_rf_data  out  64  write data
- wb_retire_valid  out  1  one instruction retired this cycle
- wb_retire_pc  out  64  retired PC
- wb_retire_src  out  2  granted source index (0 ls, 1 md, 2 ip)
- wb_instret  out  64  retired-instruction count

Behaviour:
- Reset: all outputs 0 and wb_instret = 0; buffers empty; wait counters 0. Reset mid-operation discards buffered results with no rf write.
- Handshake:
  - s_wb_ready = !buf_valid_s, a pure register output with no combinational path from any input.
  - A source result transfers when s_wb_valid && s_wb_ready.
  - Sources must not present a new valid while ready is low.
- Candidate per source: buffered entry if buf_valid_s, else the live input when s_wb_valid && s_wb_ready.
- Arbitration, each cycle among valid candidates:
  - Starved (buf_valid_s && wait_s >= STARVE_LIMIT) beats non-starved.
  - Ties go to the lowest index.
  - Exactly one grant per cycle if any candidate is valid.
- Grant effects, visible on the next clock edge (latency: input to rf write = 1 cycle):
  - wb_retire_valid = 1; wb_retire_pc = winner pc; wb_retire_src = winner index.
  - wb_rf_wen = winner wb_en && (dst != 0); wb_rf_dst = dst; wb_rf_data = result.
  - wb_instret += 1, wrapping modulo 2^64.
  - With no candidate: wb_retire_valid = 0 and wb_rf_wen = 0; data/dst/pc outputs hold their last values.
- Losers:
  - A losing live input is captured into its buffer (buf_valid set, wait = 1).
  - A losing buffered entry stays and wait increments, saturating at 2^CW-1.
  - Winner buffer clears and its wait resets to 0.
- A buffered entry always has priority over its own source's next input; per-source order is preserved.
- Worst-case latency for any result: STARVE_LIMIT + 2 cycles after capture.
- wb_en = 0 or dst = 0: retires (trace and instret update) but wb_rf_wen = 0.
- Throughput: at most 1 retire per cycle. Sustained 3-source traffic fills buffers; ready drops until drained.

Test Plan:
- Single ip result: dst = 5, result = 0x1234, pc = 0x80000000, valid for 1 cycle -> next cycle wb_rf_wen = 1, dst = 5, data = 0x1234, retire_src = 2, instret = 1.
- All three valid at once (ls dst = 1, md dst = 2, ip dst = 3) -> writes dst 1, 2, 3 on consecutive cycles; md_ready and ip_ready low until their buffers drain; instret = 3.
- ls valid every cycle while ip buffered -> ip wins on the cycle its wait reaches 3, i.e. its rf write appears no later than 5 cycles after capture; ls is accepted again immediately after.
- ip result with dst = 0, wb_en = 1 -> retire_valid = 1, wb_rf_wen = 0, instret increments.
- md result with wb_en = 0, dst = 7 -> retire_valid = 1, retire_src = 1, wb_rf_wen = 0.
- rst asserted with md and ip buffered -> next cycle all readies = 1, no rf write, instret = 0; a subsequent ls result writes normally.
